// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between the CPU (zero-latency, default owner) and a host/loader port.
// Optional macro DMEM_ARB_STARVE_EN bounds how long a latched host request can wait behind CPU traffic.
module dmem_arbiter #(
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [15:0]       c_a,
  input  logic [DATA_W-1:0] c_wd,
  output logic [DATA_W-1:0] c_rd,
  output logic              c_stall,
  input  logic              h_req,
  input  logic              h_we,
  input  logic [15:0]       h_a,
  input  logic [DATA_W-1:0] h_wd,
  output logic [DATA_W-1:0] h_rd,
  output logic              h_ack,
  output logic              h_busy,
  output logic [15:0]       m_a,
  output logic [DATA_W-1:0] m_wd,
  output logic              m_we,
  input  logic [DATA_W-1:0] m_rd
);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_SERVE, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [15:0]       hold_a_q, hold_a_d;
  logic              hold_we_q, hold_we_d;
  logic [DATA_W-1:0] hold_wd_q, hold_wd_d;
  logic [DATA_W-1:0] h_rd_q, h_rd_d;
  logic              h_ack_q, h_ack_d;
  logic              h_busy_q, h_busy_d;
  logic              serve;

`ifdef DMEM_ARB_STARVE_EN
  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
`endif

  assign serve = (state_q == S_SERVE);

  always_comb begin
    state_d   = state_q;
    hold_a_d  = hold_a_q;
    hold_we_d = hold_we_q;
    hold_wd_d = hold_wd_q;
    h_rd_d    = h_rd_q;
    h_ack_d   = 1'b0;
    h_busy_d  = h_busy_q;
`ifdef DMEM_ARB_STARVE_EN
    wait_cnt_d = wait_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (h_req) begin
          hold_a_d  = h_a;
          hold_we_d = h_we;
          hold_wd_d = h_wd;
          h_busy_d  = 1'b1;
          state_d   = S_HOLD;
`ifdef DMEM_ARB_STARVE_EN
          wait_cnt_d = '0;
`endif
        end
      end
      S_HOLD: begin
`ifdef DMEM_ARB_STARVE_EN
        if (!c_req || wait_cnt_q == CNT_MAX) state_d = S_SERVE;
        else if (wait_cnt_q != CNT_MAX)      wait_cnt_d = wait_cnt_q + 1'b1;
`else
        if (!c_req) state_d = S_SERVE;
`endif
      end
      S_SERVE: begin
        h_rd_d  = m_rd;
        h_ack_d = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        h_busy_d = 1'b0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      hold_a_q  <= '0;
      hold_we_q <= 1'b0;
      hold_wd_q <= '0;
      h_rd_q    <= '0;
      h_ack_q   <= 1'b0;
      h_busy_q  <= 1'b0;
`ifdef DMEM_ARB_STARVE_EN
      wait_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      hold_a_q  <= hold_a_d;
      hold_we_q <= hold_we_d;
      hold_wd_q <= hold_wd_d;
      h_rd_q    <= h_rd_d;
      h_ack_q   <= h_ack_d;
      h_busy_q  <= h_busy_d;
`ifdef DMEM_ARB_STARVE_EN
      wait_cnt_q <= wait_cnt_d;
`endif
    end
  end

  // Host owns the memory only in SERVE; a colliding CPU access is stalled and replayed from held inputs.
  assign m_a     = serve ? hold_a_q  : c_a;
  assign m_wd    = serve ? hold_wd_q : c_wd;
  assign m_we    = !rst && (serve ? hold_we_q : (c_req && c_we));
  assign c_stall = !rst && serve && c_req;
  assign c_rd    = m_rd;
  assign h_rd    = h_rd_q;
  assign h_ack   = h_ack_q;
  assign h_busy  = h_busy_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized + directed bench for dmem_arbiter against a transaction-level model of ownership and memory contents.
module tb_dmem_arbiter;
  localparam int DW = 32;
  localparam int SM = 4;
`ifdef DMEM_ARB_STARVE_EN
  localparam bit STARVE = 1'b1;
`else
  localparam bit STARVE = 1'b0;
`endif
  localparam int P_IDLE = 0, P_WAIT = 1, P_SERVE = 2, P_DONE = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          c_req, c_we, h_req, h_we;
  logic [15:0]   c_a, h_a, m_a;
  logic [DW-1:0] c_wd, h_wd, c_rd, h_rd, m_wd, m_rd;
  logic          c_stall, h_ack, h_busy, m_we;

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_W(DW), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_a(c_a), .c_wd(c_wd), .c_rd(c_rd), .c_stall(c_stall),
    .h_req(h_req), .h_we(h_we), .h_a(h_a), .h_wd(h_wd), .h_rd(h_rd), .h_ack(h_ack), .h_busy(h_busy),
    .m_a(m_a), .m_wd(m_wd), .m_we(m_we), .m_rd(m_rd)
  );

  // Environment memory (what the DUT really writes) and the model's idea of its contents.
  logic [DW-1:0] mem     [16];
  logic [DW-1:0] ref_mem [16];
  assign m_rd = mem[m_a[3:0]];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  int            ph = P_IDLE;
  int            cyc = 0;
  int            hold_start = 0;
  logic [15:0]   lat_a;
  logic          lat_we;
  logic [DW-1:0] lat_wd;
  logic [DW-1:0] exp_hrd;
  logic          last_stall = 1'b0;

  task automatic drive(input logic r, input logic cr, input logic cw, input logic [15:0] ca,
                       input logic [DW-1:0] cwd, input logic hr, input logic hw,
                       input logic [15:0] ha, input logic [DW-1:0] hwd);
    rst = r; c_req = cr; c_we = cw; c_a = ca; c_wd = cwd;
    h_req = hr; h_we = hw; h_a = ha; h_wd = hwd;
  endtask

  // One clock cycle: check outputs against the model, then advance memory and model at the edge.
  task automatic step();
    logic          serve;
    logic          cap_we;
    logic [15:0]   cap_a;
    logic [DW-1:0] cap_wd;
    #1;
    serve = (ph == P_SERVE);
    chk("c_stall", c_stall, !rst && serve && c_req);
    chk("m_we", m_we, rst ? 1'b0 : (serve ? lat_we : (c_req && c_we)));
    if (!rst) begin
      chk("m_a", m_a, serve ? lat_a : c_a);
      if (m_we) chk("m_wd", m_wd, serve ? lat_wd : c_wd);
      if (!serve && c_req && !c_we) chk("c_rd", c_rd, ref_mem[c_a[3:0]]);
    end
    chk("h_ack", h_ack, ph == P_DONE);
    chk("h_busy", h_busy, ph != P_IDLE);
    chk("h_rd", h_rd, exp_hrd);
    last_stall = c_stall;
    cap_we = m_we; cap_a = m_a; cap_wd = m_wd;
    @(posedge clk);
    #1;
    if (cap_we) mem[cap_a[3:0]] = cap_wd;
    if (rst) begin
      ph = P_IDLE;
      exp_hrd = '0;
    end else begin
      if (serve) begin
        exp_hrd = ref_mem[lat_a[3:0]];
        if (lat_we) ref_mem[lat_a[3:0]] = lat_wd;
      end else if (c_req && c_we) begin
        ref_mem[c_a[3:0]] = c_wd;
      end
      case (ph)
        P_IDLE: if (h_req) begin
          ph = P_WAIT; hold_start = cyc + 1;
          lat_a = h_a; lat_we = h_we; lat_wd = h_wd;
        end
        P_WAIT:  if (!c_req || (STARVE && (cyc - hold_start) >= SM)) ph = P_SERVE;
        P_SERVE: ph = P_DONE;
        default: ph = P_IDLE;
      endcase
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 16'h0, '0, 0, 0, 16'h0, '0);
      step();
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[3] = 32'h02030204;
    ref_mem[3] = 32'h02030204;
    exp_hrd = '0;
    lat_a = '0; lat_we = 1'b0; lat_wd = '0;
    drive(1, 0, 0, 16'h0, '0, 0, 0, 16'h0, '0);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);

    // Reset state, with CPU write and host request asserted to show both are gated.
    drive(1, 1, 1, 16'h0002, 32'hAAAA5555, 1, 1, 16'h0004, 32'h12345678);
    step();
    step();

    // Idle CPU, host read of 0x0003.
    drive(0, 0, 0, 16'h0, '0, 1, 0, 16'h0003, '0);
    step();
    idle_steps(4);
    chk("h_rd_read3", h_rd, 32'h02030204);

    // Host write 0x0007, then CPU reads it back.
    drive(0, 0, 0, 16'h0, '0, 1, 1, 16'h0007, 32'hDEADBEEF);
    step();
    idle_steps(3);
    drive(0, 1, 0, 16'h0007, '0, 0, 0, 16'h0, '0);
    #1;
    chk("c_rd_after_hwr", c_rd, 32'hDEADBEEF);
    step();

    // Host write collides with CPU write in SERVE; CPU write replays next cycle.
    drive(0, 0, 0, 16'h0, '0, 1, 1, 16'h0001, 32'h22222222);
    step();
    idle_steps(1);
    drive(0, 1, 1, 16'h0001, 32'h11111111, 0, 0, 16'h0, '0);
    step();
    step();
    idle_steps(2);
    chk("mem1_final", mem[1], 32'h11111111);

    // Reset while HOLD: request dropped, then a fresh one completes.
    drive(0, 1, 0, 16'h0002, '0, 1, 1, 16'h0005, 32'hCAFEF00D);
    step();
    drive(0, 1, 0, 16'h0002, '0, 0, 0, 16'h0, '0);
    step();
    drive(1, 1, 1, 16'h0002, 32'h0BADBAD0, 0, 0, 16'h0, '0);
    step();
    step();
    idle_steps(2);
    chk("busy_after_rst", h_busy, 1'b0);
    chk("mem5_untouched", mem[5], ref_mem[5]);
    drive(0, 0, 0, 16'h0, '0, 1, 0, 16'h0007, '0);
    step();
    idle_steps(4);
    chk("h_rd_post_rst", h_rd, 32'hDEADBEEF);

    // Continuous CPU reads while a host request waits.
    drive(0, 1, 0, 16'h0003, '0, 1, 0, 16'h0001, '0);
    step();
    for (int i = 0; i < 20; i++) begin
      drive(0, 1, 0, 16'h0003, '0, 0, 0, 16'h0, '0);
      step();
    end
    if (STARVE) chk("starve_done", h_busy, 1'b0);
    else        chk("cpu_priority_busy", h_busy, 1'b1);
    idle_steps(4);
    chk("h_rd_starve", h_rd, 32'h11111111);

    // Randomized traffic; CPU holds its inputs whenever it was stalled.
    for (int i = 0; i < 1500; i++) begin
      logic r;
      r = ($urandom_range(0, 59) == 0);
      if (last_stall && !r)
        drive(0, c_req, c_we, c_a, c_wd, ($urandom_range(0, 3) == 0), $urandom_range(0, 1),
              16'($urandom_range(0, 15)), $urandom);
      else
        drive(r, ($urandom_range(0, 9) < 6), $urandom_range(0, 1), 16'($urandom_range(0, 15)), $urandom,
              ($urandom_range(0, 3) == 0), $urandom_range(0, 1), 16'($urandom_range(0, 15)), $urandom);
      step();
    end
    idle_steps(6);
    for (int i = 0; i < 16; i++) chk("mem_final", mem[i], ref_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
